// File: rtl/mux_nto1_rr_if.sv
// Stream bundle for mux_nto1_rr: CHANNELS packed producer lanes in, one consumer lane out.
// The slave modport is the mux's view; master is the surrounding environment.
interface mux_nto1_rr_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_valid;
    logic                      out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/mux_nto1_rr.sv
// N:1 valid/ready stream mux with round-robin arbitration and a registered output slot.
// Define MUX_NTO1_FIXED_PRIO_EN to replace round-robin with lowest-index-wins priority.
module mux_nto1_rr #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
) (
    input logic          clk,
    input logic          rst_n,
    mux_nto1_rr_if.slave bus
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [WIDTH-1:0]    data_q;
    logic [SEL_W-1:0]    sel_q;

    logic                load_en;
    logic                accept;
    logic                grant_any;
    logic [SEL_W-1:0]    grant_idx;
    logic [SEL_W-1:0]    lo_idx;
    logic [CHANNELS-1:0] grant_oh;

`ifndef MUX_NTO1_FIXED_PRIO_EN
    logic [SEL_W-1:0]    rr_ptr;
    logic                hi_any;
    logic [SEL_W-1:0]    hi_idx;
`endif

    // The slot can take a beat when it is empty or being drained this cycle.
    assign load_en = (state_q == EMPTY) || bus.out_ready;
    assign accept  = grant_any && load_en && rst_n;

    // Scan downward so the lowest qualifying index is the last one written.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant_any = 1'b0;
        lo_idx    = '0;
`ifndef MUX_NTO1_FIXED_PRIO_EN
        hi_any    = 1'b0;
        hi_idx    = '0;
`endif
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                grant_any = 1'b1;
                lo_idx    = SEL_W'(i);
`ifndef MUX_NTO1_FIXED_PRIO_EN
                if (i >= int'(rr_ptr)) begin
                    hi_any = 1'b1;
                    hi_idx = SEL_W'(i);
                end
`endif
            end
        end
`ifdef MUX_NTO1_FIXED_PRIO_EN
        grant_idx = lo_idx;
`else
        // A valid channel at or above the pointer wins; otherwise wrap to the lowest.
        grant_idx = hi_any ? hi_idx : lo_idx;
`endif
    end

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            grant_oh[i] = grant_any && (grant_idx == SEL_W'(i));
        end
    end

    assign bus.in_ready = grant_oh & {CHANNELS{load_en && rst_n}};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (accept) begin
                    state_d = FULL;
                end else if (bus.out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            sel_q  <= '0;
        end else if (accept) begin
            data_q <= bus.in_data[grant_idx*WIDTH +: WIDTH];
            sel_q  <= grant_idx;
        end
    end

`ifndef MUX_NTO1_FIXED_PRIO_EN
    // The pointer moves only on an accepted beat, to the slot after the winner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_mux_nto1_rr.sv
// Directed bench for mux_nto1_rr: a cycle table on the 4x4 build plus a hand
// sequence on an 8-bit, 3-channel build.
module tb_mux_nto1_rr;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mux_nto1_rr_if #(.WIDTH(4), .CHANNELS(4)) bus4 ();
    mux_nto1_rr_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();

    mux_nto1_rr #(.WIDTH(4), .CHANNELS(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    mux_nto1_rr #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [15:0] data;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [3:0]  exp_od;
        logic [1:0]  exp_os;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic [15:0] d, input logic o,
                       input logic [3:0] er, input logic ev, input logic [3:0] ed, input logic [1:0] es);
        vec_t t;
        t.rst_n = r; t.valid = v; t.data = d; t.ordy = o;
        t.exp_rdy = er; t.exp_ov = ev; t.exp_od = ed; t.exp_os = es;
        vecs.push_back(t);
    endtask

    logic [23:0] d3;
    logic [7:0]  exp_byte;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus4.in_valid  = '0;
        bus4.in_data   = '0;
        bus4.out_ready = 1'b0;
        bus3.in_valid  = '0;
        bus3.in_data   = '0;
        bus3.out_ready = 1'b0;

        // rst, valid, data, ordy | in_ready before edge | valid, data, sel after edge
        // Reset held with everything valid: nothing granted, outputs cleared.
        add(0, 4'hF, 16'hDCBA, 1, 4'h0, 0, 4'h0, 2'd0);
        add(0, 4'hF, 16'hDCBA, 1, 4'h0, 0, 4'h0, 2'd0);
        // Fairness: 0,1,2,3,0,1 with one beat per cycle.
        add(1, 4'hF, 16'hDCBA, 1, 4'h1, 1, 4'hA, 2'd0);
        add(1, 4'hF, 16'hDCBA, 1, 4'h2, 1, 4'hB, 2'd1);
        add(1, 4'hF, 16'hDCBA, 1, 4'h4, 1, 4'hC, 2'd2);
        add(1, 4'hF, 16'hDCBA, 1, 4'h8, 1, 4'hD, 2'd3);
        add(1, 4'hF, 16'hDCBA, 1, 4'h1, 1, 4'hA, 2'd0);
        add(1, 4'hF, 16'hDCBA, 1, 4'h2, 1, 4'hB, 2'd1);
        // Drain, then take channel 3 alone so the pointer wraps to 0.
        add(1, 4'h0, 16'hDCBA, 1, 4'h0, 0, 4'hB, 2'd1);
        add(1, 4'h8, 16'hDCBA, 1, 4'h8, 1, 4'hD, 2'd3);
        // Idle channels skipped: 1,3,1,3.
        add(1, 4'hA, 16'hDCBA, 1, 4'h2, 1, 4'hB, 2'd1);
        add(1, 4'hA, 16'hDCBA, 1, 4'h8, 1, 4'hD, 2'd3);
        add(1, 4'hA, 16'hDCBA, 1, 4'h2, 1, 4'hB, 2'd1);
        add(1, 4'hA, 16'hDCBA, 1, 4'h8, 1, 4'hD, 2'd3);
        // Backpressure: channel 2 holds 5 for three stalled cycles, then channel 3 with no bubble.
        add(1, 4'h4, 16'hD5BA, 1, 4'h4, 1, 4'h5, 2'd2);
        add(1, 4'h9, 16'hD5BA, 0, 4'h0, 1, 4'h5, 2'd2);
        add(1, 4'h9, 16'hD5BA, 0, 4'h0, 1, 4'h5, 2'd2);
        add(1, 4'h9, 16'hD5BA, 0, 4'h0, 1, 4'h5, 2'd2);
        add(1, 4'h9, 16'hD5BA, 1, 4'h8, 1, 4'hD, 2'd3);
        // Idle cycles leave the pointer at 1.
        add(1, 4'h1, 16'hDCBA, 1, 4'h1, 1, 4'hA, 2'd0);
        add(1, 4'h0, 16'hDCBA, 1, 4'h0, 0, 4'hA, 2'd0);
        add(1, 4'h0, 16'hDCBA, 1, 4'h0, 0, 4'hA, 2'd0);
        add(1, 4'hF, 16'hDCBA, 1, 4'h2, 1, 4'hB, 2'd1);
        // Reset while stalled: held beat B is dropped, pointer back to 0.
        add(1, 4'hF, 16'hDCBA, 0, 4'h0, 1, 4'hB, 2'd1);
        add(0, 4'hF, 16'hDCBA, 0, 4'h0, 0, 4'h0, 2'd0);
        add(1, 4'hF, 16'hDCBA, 1, 4'h1, 1, 4'hA, 2'd0);
        add(1, 4'h0, 16'hDCBA, 1, 4'h0, 0, 4'hA, 2'd0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n          = vecs[i].rst_n;
            bus4.in_valid  = vecs[i].valid;
            bus4.in_data   = vecs[i].data;
            bus4.out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d in_ready", i), 32'(bus4.in_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), 32'(bus4.out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("v%0d out_data", i), 32'(bus4.out_data), 32'(vecs[i].exp_od));
            check($sformatf("v%0d out_sel", i), 32'(bus4.out_sel), 32'(vecs[i].exp_os));
        end

        // 8-bit, 3-channel build: grants wrap at 2, each byte taken from its own slice.
        bus4.in_valid  = '0;
        d3             = {8'h7E, 8'hC3, 8'h5A};
        bus3.in_data   = d3;
        bus3.in_valid  = 3'b111;
        bus3.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("w3 beat%0d in_ready", k), 32'(bus3.in_ready), 32'(3'b001 << (k % 3)));
            @(posedge clk);
            #1;
            exp_byte = d3[(k % 3) * 8 +: 8];
            check($sformatf("w3 beat%0d out_valid", k), 32'(bus3.out_valid), 32'd1);
            check($sformatf("w3 beat%0d out_sel", k), 32'(bus3.out_sel), 32'(k % 3));
            check($sformatf("w3 beat%0d out_data", k), 32'(bus3.out_data), 32'(exp_byte));
        end
        // Stall the 3-channel build: output held, nothing ready.
        bus3.out_ready = 1'b0;
        #1;
        check("w3 stall in_ready", 32'(bus3.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("w3 stall out_sel", 32'(bus3.out_sel), 32'd2);
        check("w3 stall out_data", 32'(bus3.out_data), 32'h7E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
